// File: rtl/wb_stage_pkg.sv
// wb_stage_pkg: shared bus widths, CSR numbers, exception codes and the memory-to-writeback bus layout
package wb_stage_pkg;
  localparam int MS_TO_WS_BUS_WD = 199;
  localparam int WS_TO_RF_BUS_WD = 38;
  localparam int WS_FWD_BUS_WD = 39;
  localparam logic [13:0] CSR_CRMD = 14'h0;
  localparam logic [13:0] CSR_PRMD = 14'h1;
  localparam logic [13:0] CSR_ECFG = 14'h4;
  localparam logic [13:0] CSR_ESTAT = 14'h5;
  localparam logic [13:0] CSR_ERA = 14'h6;
  localparam logic [13:0] CSR_BADV = 14'h7;
  localparam logic [13:0] CSR_EENTRY = 14'hc;
  localparam logic [13:0] CSR_SAVE0 = 14'h30;
  localparam logic [13:0] CSR_SAVE1 = 14'h31;
  localparam logic [13:0] CSR_SAVE2 = 14'h32;
  localparam logic [13:0] CSR_SAVE3 = 14'h33;
  localparam logic [13:0] CSR_TID = 14'h40;
  localparam logic [13:0] CSR_TCFG = 14'h41;
  localparam logic [13:0] CSR_TVAL = 14'h42;
  localparam logic [13:0] CSR_TICLR = 14'h44;
  localparam logic [5:0] ECODE_INT = 6'h00;
  localparam logic [5:0] ECODE_ADEF = 6'h08;
  localparam logic [5:0] ECODE_ALE = 6'h09;
  localparam logic [5:0] ECODE_SYS = 6'h0b;
  localparam logic [5:0] ECODE_BRK = 6'h0c;
  localparam logic [5:0] ECODE_INE = 6'h0d;
  typedef struct packed {
    logic [31:0] vaddr;
    logic [8:0] esubcode;
    logic ex;
    logic ertn;
    logic [31:0] csr_wvalue;
    logic [5:0] ecode;
    logic csr_re;
    logic csr_we;
    logic [13:0] csr_num;
    logic [31:0] csr_wmask;
    logic gr_we;
    logic [4:0] dest;
    logic [31:0] result;
    logic [31:0] pc;
  } ms_to_ws_t;
endpackage

// File: rtl/wb_stage_if.sv
// wb_stage_if: memory-to-writeback handshake (ms_to_ws_valid, ms_to_ws_bus from master; ws_allowin from slave)
interface wb_stage_if;
  import wb_stage_pkg::*;
  logic ms_to_ws_valid;
  logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus;
  logic ws_allowin;
  modport master(output ms_to_ws_valid, ms_to_ws_bus, input ws_allowin);
  modport slave(input ms_to_ws_valid, ms_to_ws_bus, output ws_allowin);
endinterface

// File: rtl/wb_stage_csr_regfile.sv
// csr_regfile: CSR storage, stable timer, read mux, exception/ertn update, has_int (csr_* access, *_commit events, ex_entry/era_pc/has_int out)
module csr_regfile
  import wb_stage_pkg::*;
#(
  parameter logic [31:0] COREID = 32'd0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [13:0] csr_num,
  input  logic        csr_we,
  input  logic [31:0] csr_wmask,
  input  logic [31:0] csr_wvalue,
  input  logic        ex_commit,
  input  logic        ertn_commit,
  input  logic [5:0]  ecode,
  input  logic [8:0]  esubcode,
  input  logic [31:0] pc,
  input  logic [31:0] vaddr,
  output logic [31:0] csr_rvalue,
  output logic [31:0] ex_entry,
  output logic [31:0] era_pc,
  output logic        has_int
);
  logic [1:0] crmd_plv, prmd_pplv, estat_swi;
  logic crmd_ie, crmd_da, prmd_pie, estat_ti, tcfg_en, tcfg_per;
  logic [12:0] ecfg_lie, estat_is;
  logic [5:0] estat_ecode;
  logic [8:0] estat_esub;
  logic [31:0] era, badv, tid, tval, nv;
  logic [25:0] eentry_va;
  logic [29:0] tcfg_init;
  logic [31:0] save [4];
  logic expire;
  function automatic logic hit(input logic [13:0] n);
    return csr_we && csr_num == n;
  endfunction
  assign estat_is = {1'b0, estat_ti, 9'b0, estat_swi};
  assign nv = (csr_rvalue & ~csr_wmask) | (csr_wvalue & csr_wmask);
  assign expire = tcfg_en && tval == 32'd0;
  assign has_int = crmd_ie & |(estat_is & ecfg_lie);
  assign ex_entry = {eentry_va, 6'b0};
  assign era_pc = era;
  always_comb begin
    case (csr_num)
      CSR_CRMD: csr_rvalue = {28'b0, crmd_da, crmd_ie, crmd_plv};
      CSR_PRMD: csr_rvalue = {29'b0, prmd_pie, prmd_pplv};
      CSR_ECFG: csr_rvalue = {19'b0, ecfg_lie};
      CSR_ESTAT: csr_rvalue = {1'b0, estat_esub, estat_ecode, 3'b0, estat_is};
      CSR_ERA: csr_rvalue = era;
      CSR_BADV: csr_rvalue = badv;
      CSR_EENTRY: csr_rvalue = ex_entry;
      CSR_SAVE0, CSR_SAVE1, CSR_SAVE2, CSR_SAVE3: csr_rvalue = save[csr_num[1:0]];
      CSR_TID: csr_rvalue = tid;
      CSR_TCFG: csr_rvalue = {tcfg_init, tcfg_per, tcfg_en};
      CSR_TVAL: csr_rvalue = tval;
      default: csr_rvalue = 32'b0;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      {crmd_da, crmd_ie, crmd_plv} <= 4'b1000;
      {prmd_pie, prmd_pplv} <= 3'b0;
      ecfg_lie <= 13'b0;
      {estat_swi, estat_ti, estat_ecode, estat_esub} <= '0;
      era <= 32'b0;
      badv <= 32'b0;
      eentry_va <= 26'b0;
      save <= '{default: 32'b0};
      tid <= COREID;
      {tcfg_init, tcfg_per, tcfg_en} <= 32'b0;
      tval <= 32'b0;
    end else begin
      if (ex_commit) begin
        {prmd_pie, prmd_pplv} <= {crmd_ie, crmd_plv};
        {crmd_ie, crmd_plv} <= 3'b0;
        era <= pc;
        estat_ecode <= ecode;
        estat_esub <= esubcode;
        if (ecode == ECODE_ADEF) badv <= pc;
        else if (ecode == ECODE_ALE) badv <= vaddr;
      end else if (ertn_commit) {crmd_ie, crmd_plv} <= {prmd_pie, prmd_pplv};
      if (hit(CSR_CRMD)) {crmd_da, crmd_ie, crmd_plv} <= nv[3:0];
      if (hit(CSR_PRMD)) {prmd_pie, prmd_pplv} <= nv[2:0];
      if (hit(CSR_ECFG)) ecfg_lie <= nv[12:0];
      if (hit(CSR_ESTAT)) estat_swi <= nv[1:0];
      if (hit(CSR_ERA)) era <= nv;
      if (hit(CSR_BADV)) badv <= nv;
      if (hit(CSR_EENTRY)) eentry_va <= nv[31:6];
      if (hit(CSR_TID)) tid <= nv;
      if (csr_we && csr_num[13:2] == CSR_SAVE0[13:2]) save[csr_num[1:0]] <= nv;
      // expiry beats a same-cycle TICLR clear
      estat_ti <= expire | (estat_ti & ~(hit(CSR_TICLR) & nv[0]));
      if (hit(CSR_TCFG)) {tcfg_init, tcfg_per, tcfg_en} <= nv;
      else if (expire && !tcfg_per) tcfg_en <= 1'b0;
      tval <= hit(CSR_TCFG) ? {nv[31:2], 2'b00} :
              expire ? (tcfg_per ? {tcfg_init, 2'b00} : 32'hffff_ffff) :
              tcfg_en ? tval - 32'd1 : tval;
    end
  end
endmodule

// File: rtl/wb_stage.sv
// wb_stage: write-back stage (ms_ws handshake in; RF write, forwarding, flush/redirect, has_int, retire trace out)
module wb_stage
  import wb_stage_pkg::*;
#(
  parameter logic [31:0] COREID = 32'd0
) (
  input  logic                       clk,
  input  logic                       reset,
  wb_stage_if.slave                  ms_ws,
  output logic [WS_TO_RF_BUS_WD-1:0] ws_to_rf_bus,
  output logic [WS_FWD_BUS_WD-1:0]   ws_fwd_bus,
  output logic                       ws_flush_pipe,
  output logic [31:0]                ws_flush_pc,
  output logic                       has_int,
  output logic [31:0]                debug_wb_pc,
  output logic [3:0]                 debug_wb_rf_we,
  output logic [4:0]                 debug_wb_rf_wnum,
  output logic [31:0]                debug_wb_rf_wdata
);
  ms_to_ws_t r;
  logic ws_valid, live, rf_we;
  logic [31:0] csr_rvalue, ex_entry, era_pc, final_result;
  assign ms_ws.ws_allowin = !ws_valid | 1'b1;
  always_ff @(posedge clk) begin
    if (reset) ws_valid <= 1'b0;
    else if (ms_ws.ws_allowin) ws_valid <= ms_ws.ms_to_ws_valid;
  end
  always_ff @(posedge clk) begin
    if (ms_ws.ms_to_ws_valid && ms_ws.ws_allowin) r <= ms_ws.ms_to_ws_bus;
  end
  // an instruction caught by reset must not commit anything on the reset edge
  assign live = ws_valid & !reset;
  assign rf_we = live & r.gr_we & !r.ex;
  assign final_result = r.csr_re ? csr_rvalue : r.result;
  assign ws_to_rf_bus = {rf_we, r.dest, final_result};
  assign ws_fwd_bus = {r.csr_re & live, live & r.gr_we, r.dest, final_result};
  assign ws_flush_pipe = live & (r.ex | r.ertn);
  assign ws_flush_pc = r.ex ? ex_entry : era_pc;
  assign debug_wb_pc = r.pc;
  assign debug_wb_rf_we = {4{rf_we}};
  assign debug_wb_rf_wnum = r.dest;
  assign debug_wb_rf_wdata = final_result;
  csr_regfile #(.COREID(COREID)) u_csr (
    .clk(clk),
    .reset(reset),
    .csr_num(r.csr_num),
    .csr_we(live & r.csr_we & !r.ex),
    .csr_wmask(r.csr_wmask),
    .csr_wvalue(r.csr_wvalue),
    .ex_commit(live & r.ex),
    .ertn_commit(live & r.ertn),
    .ecode(r.ecode),
    .esubcode(r.esubcode),
    .pc(r.pc),
    .vaddr(r.vaddr),
    .csr_rvalue(csr_rvalue),
    .ex_entry(ex_entry),
    .era_pc(era_pc),
    .has_int(has_int)
  );
endmodule
